// File: rtl/iir_inverse_decoder.sv
// Receiving-end inverse of a first-order sign-magnitude IIR: recovers x from filtered y
// through one shared multiplier. Define IIR_INV_OVF_FLAG_EN to add the sticky ovf_o port.
module iir_inverse_decoder #(
  parameter int unsigned N_BITS    = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic [N_BITS-1:0] y_i,
  input  logic              y_valid_i,
  output logic              y_ready_o,
  input  logic [N_BITS-1:0] rb0_i,
  input  logic [N_BITS-1:0] b1_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] offset_i,
  output logic [N_BITS-1:0] x_o,
  output logic              x_valid_o,
  input  logic              x_ready_i
`ifdef IIR_INV_OVF_FLAG_EN
  ,
  output logic              ovf_o
`endif
);

  localparam int unsigned M = N_BITS - 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MB1  = 3'd1;
  localparam logic [2:0] MRB0 = 3'd2;
  localparam logic [2:0] MA   = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  // Result format for the helpers: {overflow, sign, magnitude}; -0 is folded to +0.
  function automatic logic [N_BITS:0] sm_mul(input logic [N_BITS-1:0] a,
                                              input logic [N_BITS-1:0] c);
    logic [2*M-1:0] prod;
    logic [2*M-1:0] shifted;
    logic           ov;
    logic [M-1:0]   mag;
    prod    = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, c[M-1:0]};
    shifted = prod >> FRAC_BITS;
    ov      = |shifted[2*M-1:M];
    mag     = ov ? '1 : shifted[M-1:0];
    return {ov, (a[M] ^ c[M]) & (|mag), mag};
  endfunction

  function automatic logic [N_BITS:0] sm_add(input logic [N_BITS-1:0] a,
                                              input logic [N_BITS-1:0] c);
    logic [M:0]   sum;
    logic         ov;
    logic         s;
    logic [M-1:0] mag;
    ov  = 1'b0;
    sum = '0;
    if (a[M] == c[M]) begin
      sum = {1'b0, a[M-1:0]} + {1'b0, c[M-1:0]};
      ov  = sum[M];
      mag = ov ? '1 : sum[M-1:0];
      s   = a[M];
    end else if (a[M-1:0] >= c[M-1:0]) begin
      mag = a[M-1:0] - c[M-1:0];
      s   = a[M];
    end else begin
      mag = c[M-1:0] - a[M-1:0];
      s   = c[M];
    end
    return {ov, s & (|mag), mag};
  endfunction

  function automatic logic [N_BITS-1:0] sm_neg(input logic [N_BITS-1:0] v);
    return {~v[M], v[M-1:0]};
  endfunction

  logic [2:0]        state;
  logic [N_BITS-1:0] y_r, rb0_r, b1_r, a_r, off_r;
  logic [N_BITS-1:0] t_r, w0_r, w1;
  logic [N_BITS-1:0] mul_a, mul_c;
  logic [N_BITS:0]   prod_res, t_res, s_res, x_res;
  logic              sat_evt;

  // The single multiplier's operands follow the FSM step; the adders are cheap so each
  // step's sum is formed from whatever the multiplier yields in that cycle.
  always_comb begin
    mul_a = a_r;
    mul_c = w1;
    case (state)
      MB1:     begin mul_a = b1_r;  mul_c = w1;  end
      MRB0:    begin mul_a = rb0_r; mul_c = t_r; end
      default: ;
    endcase
    prod_res = sm_mul(mul_a, mul_c);
    t_res    = sm_add(y_r, sm_neg(prod_res[N_BITS-1:0]));
    s_res    = sm_add(w0_r, prod_res[N_BITS-1:0]);
    x_res    = sm_add(s_res[N_BITS-1:0], sm_neg(off_r));
    case (state)
      MB1:     sat_evt = prod_res[N_BITS] | t_res[N_BITS];
      MRB0:    sat_evt = prod_res[N_BITS];
      MA:      sat_evt = prod_res[N_BITS] | s_res[N_BITS] | x_res[N_BITS];
      default: sat_evt = 1'b0;
    endcase
  end

  assign y_ready_o = (state == IDLE);
  assign x_valid_o = (state == OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      y_r   <= '0;
      rb0_r <= '0;
      b1_r  <= '0;
      a_r   <= '0;
      off_r <= '0;
      t_r   <= '0;
      w0_r  <= '0;
      w1    <= '0;
      x_o   <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      w1    <= '0;
    end else begin
      case (state)
        IDLE: if (y_valid_i) begin
          y_r   <= y_i;
          rb0_r <= rb0_i;
          b1_r  <= b1_i;
          a_r   <= a_i;
          off_r <= offset_i;
          state <= MB1;
        end
        MB1: begin
          t_r   <= t_res[N_BITS-1:0];
          state <= MRB0;
        end
        MRB0: begin
          w0_r  <= prod_res[N_BITS-1:0];
          state <= MA;
        end
        MA: begin
          x_o   <= x_res[N_BITS-1:0];
          w1    <= w0_r;
          state <= OUT;
        end
        OUT: if (x_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IIR_INV_OVF_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf_o <= 1'b0;
    else if (clear_i) ovf_o <= 1'b0;
    else if (sat_evt) ovf_o <= 1'b1;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_evt;
`endif

endmodule

// File: tb/tb_iir_inverse_decoder.sv
// Bench for iir_inverse_decoder: directed cases plus random samples checked against a
// signed-integer reference model of the inverse filter.
module tb_iir_inverse_decoder;

  logic        clk, reset, clear_i;
  logic [31:0] y_i, rb0_i, b1_i, a_i, offset_i;
  logic        y_valid_i, y_ready_o;
  logic [31:0] x_o;
  logic        x_valid_o, x_ready_i;
`ifdef IIR_INV_OVF_FLAG_EN
  logic        ovf;
`endif

  iir_inverse_decoder #(.N_BITS(32), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear_i),
    .y_i       (y_i),
    .y_valid_i (y_valid_i),
    .y_ready_o (y_ready_o),
    .rb0_i     (rb0_i),
    .b1_i      (b1_i),
    .a_i       (a_i),
    .offset_i  (offset_i),
    .x_o       (x_o),
    .x_valid_o (x_valid_o),
    .x_ready_i (x_ready_i)
`ifdef IIR_INV_OVF_FLAG_EN
    ,
    .ovf_o     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: values as signed integers scaled by 2^16, clamped to +/-(2^31-1).
  localparam longint MAXM = 64'h0000_0000_7FFF_FFFF;
  longint mw1  = 0;
  bit     movf = 1'b0;

  function automatic longint dec(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXM)  begin movf = 1'b1; return MAXM;  end
    if (v < -MAXM) begin movf = 1'b1; return -MAXM; end
    return v;
  endfunction

  function automatic logic [31:0] enc(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[30:0]};
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] y, rb0, b1, a, off);
    longint p, t, w0, m, s, x;
    p   = sat((dec(b1) * mw1) / 65536);
    t   = sat(dec(y) - p);
    w0  = sat((dec(rb0) * t) / 65536);
    m   = sat((dec(a) * mw1) / 65536);
    s   = sat(w0 + m);
    x   = sat(s - dec(off));
    mw1 = w0;
    return enc(x);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) begin
      v = $urandom();
    end else begin
      v     = $urandom_range(0, 32'h0003_FFFF);
      v[31] = 1'($urandom_range(0, 1));
    end
    return v;
  endfunction

  task automatic pulse_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    mw1  = 0;
    movf = 1'b0;
  endtask

  // One full transaction: offer y, hold x_ready low for 'stall' cycles in OUT, then drain.
  task automatic run_sample(input logic [31:0] y, rb0, b1, a, off, input int stall,
                            output logic [31:0] got);
    logic [31:0] exp_x;
    int          lat;
    exp_x = model_step(y, rb0, b1, a, off);
    @(negedge clk);
    check_bit("ready_idle", y_ready_o, 1'b1);
    y_i = y; rb0_i = rb0; b1_i = b1; a_i = a; offset_i = off;
    y_valid_i = 1'b1;
    @(negedge clk);
    // Coefficients changing after the accept must not disturb the sample in flight.
    y_valid_i = 1'b0;
    y_i = $urandom(); rb0_i = $urandom(); b1_i = $urandom(); a_i = $urandom();
    offset_i = $urandom();
    lat = 1;
    check_bit("ready_busy", y_ready_o, 1'b0);
    while (!x_valid_o && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    // x_valid appears after the 4th edge counting the accept edge itself.
    check("latency", lat, 32'd4);
    check("x_o", x_o, exp_x);
    got = x_o;
`ifdef IIR_INV_OVF_FLAG_EN
    check_bit("ovf", ovf, movf);
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_bit("bp_valid", x_valid_o, 1'b1);
      check("bp_hold", x_o, exp_x);
      check_bit("bp_ready", y_ready_o, 1'b0);
    end
    x_ready_i = 1'b1;
    @(negedge clk);
    x_ready_i = 1'b0;
    check_bit("drained_valid", x_valid_o, 1'b0);
    check_bit("drained_ready", y_ready_o, 1'b1);
  endtask

  // Start a unity sample and kill it: mode 0 = clear_i in MRB0, mode 1 = async reset in MA.
  task automatic abort_sample(input int mode);
    bit seen;
    @(negedge clk);
    y_i = 32'h0005_0000; rb0_i = 32'h0001_0000; b1_i = 32'h0000_8000;
    a_i = 32'h0000_8000; offset_i = '0;
    y_valid_i = 1'b1;
    @(negedge clk);
    y_valid_i = 1'b0;
    @(negedge clk);
    if (mode == 0) begin
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
    end else begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mid_x", x_o, 32'h0);
      check_bit("rst_mid_valid", x_valid_o, 1'b0);
      @(negedge clk);
      reset = 1'b1;
    end
    mw1  = 0;
    movf = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= x_valid_o;
    end
    check_bit("abort_no_valid", seen, 1'b0);
    check_bit("abort_ready", y_ready_o, 1'b1);
  endtask

  logic [31:0] got;

  initial begin
    reset = 1'b0; clear_i = 1'b0; y_valid_i = 1'b0; x_ready_i = 1'b0;
    y_i = '0; rb0_i = '0; b1_i = '0; a_i = '0; offset_i = '0;
    repeat (2) @(negedge clk);
    check("rst_x", x_o, 32'h0);
    check_bit("rst_valid", x_valid_o, 1'b0);
`ifdef IIR_INV_OVF_FLAG_EN
    check_bit("rst_ovf", ovf, 1'b0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check_bit("rst_ready", y_ready_o, 1'b1);

    run_sample(32'h0003_0000, 32'h0001_0000, '0, '0, '0, 0, got);
    check("unity", got, 32'h0003_0000);
    run_sample(32'h0004_0000, 32'h0000_8000, '0, '0, 32'h0001_0000, 0, got);
    check("gain_offset", got, 32'h0001_0000);

    pulse_clear();
    run_sample(32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, '0, 0, got);
    check("memory_1", got, 32'h0001_0000);
    run_sample(32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, '0, 0, got);
    check("memory_2", got, 32'h0000_C000);

    run_sample(32'h0002_8000, 32'h0001_0000, 32'h0000_4000, 32'h0000_2000, '0, 3, got);

    pulse_clear();
    run_sample(32'h8001_0000, 32'h0001_0000, '0, '0, '0, 0, got);
    check("neg_unity", got, 32'h8001_0000);
    run_sample(32'h7FFF_0000, 32'h7FFF_0000, '0, '0, '0, 1, got);
    check("saturate", got, 32'h7FFF_FFFF);
`ifdef IIR_INV_OVF_FLAG_EN
    check_bit("ovf_sat", ovf, 1'b1);
`endif

    abort_sample(0);
    run_sample(32'h0002_0000, 32'h0001_0000, '0, '0, '0, 0, got);
    check("after_clear", got, 32'h0002_0000);
    abort_sample(1);
    run_sample(32'h0002_0000, 32'h0001_0000, '0, '0, '0, 0, got);
    check("after_reset", got, 32'h0002_0000);
    run_sample(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, '0, 0, got);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) pulse_clear();
      run_sample(rnd_word(), rnd_word(), rnd_word(), rnd_word(), rnd_word(),
                 int'($urandom_range(0, 3)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
